// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared AES decryption datapath definitions: state geometry, FSM encoding and
// byte-slice helpers for the column-major 128-bit state word.
package aes_dec_pkg;

  localparam int unsigned AES_STATE_W   = 128;
  localparam int unsigned AES_NUM_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Byte i lives at [127-8i -: 8]; byte 0 is the most significant.
  function automatic logic [7:0] get_byte(input logic [AES_STATE_W-1:0] s,
                                          input int unsigned i);
    return s[AES_STATE_W-1-8*i -: 8];
  endfunction

  function automatic logic [AES_STATE_W-1:0] set_byte(input logic [AES_STATE_W-1:0] s,
                                                      input int unsigned i,
                                                      input logic [7:0] b);
    logic [AES_STATE_W-1:0] r;
    r = s;
    r[AES_STATE_W-1-8*i -: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_iter_if.sv
// Upstream and downstream valid/ready channels of the InvSubBytes stage.
interface inv_sub_bytes_iter_if;
  import aes_dec_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] state_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] state_out;
  logic                   busy;

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );

endinterface

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// Combinational FIPS-197 inverse S-box, one byte in, one byte out.
module inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes BYTES_PER_CYCLE bytes of the captured
// state per clock through a shared bank of inverse S-boxes.
module inv_sub_bytes_iter
  import aes_dec_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  inv_sub_bytes_iter_if.slave bus
);

  localparam int unsigned N     = AES_NUM_BYTES / BYTES_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!(BYTES_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_param
    $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_e                 state, state_next;
  logic [AES_STATE_W-1:0] work, work_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   in_ready_c, out_valid_c;
  logic [7:0]             sb_in  [BYTES_PER_CYCLE];
  logic [7:0]             sb_out [BYTES_PER_CYCLE];

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
    assign sb_in[j] = get_byte(work, 32'(cnt) * BYTES_PER_CYCLE + j);
    inv_sbox u_inv_sbox (
      .in_byte  (sb_in[j]),
      .out_byte (sb_out[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      work  <= work_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    work_next   = work;
    cnt_next    = cnt;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          work_next  = bus.state_in;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
          work_next = set_byte(work_next, 32'(cnt) * BYTES_PER_CYCLE + j, sb_out[j]);
        end
        if (cnt == CNT_W'(N - 1)) state_next = DONE;
        else                      cnt_next   = cnt + 1'b1;
      end
      DONE: begin
        out_valid_c = 1'b1;
        // Accepting while the result drains keeps back-to-back words at N+1 cycles.
        in_ready_c  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            work_next  = bus.state_in;
            cnt_next   = '0;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.state_out = work;
  assign bus.busy      = (state != IDLE);

endmodule

// File: doc/inv_sub_bytes_iter.md
# inv_sub_bytes_iter

Iterative InvSubBytes stage of the AES-128 decryption datapath. It sits directly downstream of the inverse row-shifting stage. It accepts one 128-bit state word over a valid/ready handshake and substitutes every byte through the AES inverse S-box, BYTES_PER_CYCLE bytes per clock. It then presents the result to the AddRoundKey stage over a second valid/ready handshake. Trading latency for area lets the decryption round share a small number of inverse S-box instances.

## Interface
- BYTES_PER_CYCLE, default 4: inverse S-box instances. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  state_in holds a valid state word.
- in_ready  output  1  block can accept a word this cycle.
- state_in  input  128  state word. Byte 0 is [127:120] and byte 15 is [7:0]. Layout is column-major: column c occupies [127-32c -: 32].
- out_valid  output  1  state_out holds a completed result.
- out_ready  input  1  downstream accepts the result this cycle.
- state_out  output  128  substituted state, same byte layout as state_in.
- busy  output  1  high whenever FSM is not IDLE.

## Operation
- Definitions:
  - N = 16 / BYTES_PER_CYCLE.
  - Internal registers: 128-bit work register `work`, and chunk counter `cnt` of width max(1, log2 N).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: load work <= state_in, cnt <= 0, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, replace bytes cnt*B .. cnt*B+B-1 of work with InvSbox(byte), where B = BYTES_PER_CYCLE.
  - Unprocessed bytes are held.
  - When cnt == N-1: go to DONE. Otherwise cnt <= cnt+1.
- DONE:
  - out_valid = 1; state_out = work.
  - in_ready = out_ready, so a new word is accepted on the same edge the result is consumed.
  - out_ready=1 and in_valid=1: load the new word, cnt <= 0, go to RUN.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=0: remain in DONE. work, state_out and out_valid hold.
- Output behaviour:
  - state_out is driven from work in every state; it is meaningful only while out_valid is high.
  - out_valid = (state == DONE).
- Reset, asserted at any time including mid-RUN:
  - Immediately: FSM to IDLE, work = 0, cnt = 0.
  - Outputs during and after reset: out_valid = 0, busy = 0, in_ready = 1, state_out = 0.
  - An in-flight word is discarded; no partial result is ever presented.
- Input rules:
  - in_valid while in_ready=0 is ignored (no capture).
  - The upstream stage must hold in_valid and state_in until the handshake completes.

## Timing
- Handshake at edge k: processing occurs on edges k+1 .. k+N.
- out_valid rises after edge k+N, so latency is N cycles (4 at the default).
- Sustained throughput with out_ready held high: one word per N+1 cycles.
- in_ready and out_valid depend only on registered state, plus out_ready in DONE.
- Combinational path: out_ready -> in_ready only. No path from in_valid to any output.
- Reset is asynchronous assert. Deassertion is synchronised externally; the block needs no extra cycles after it.

## Structure
- Package aes_dec_pkg holds:
  - AES_STATE_W = 128 and AES_NUM_BYTES = 16.
  - The FSM state enum {IDLE, RUN, DONE}.
  - A byte-index helper mapping byte i to bit slice [127-8i -: 8].
- Sub-module inv_sbox: purely combinational, 8-bit in to 8-bit out, full 256-entry FIPS-197 inverse S-box.
  - Instantiated BYTES_PER_CYCLE times.
  - Its inputs are muxed from work by cnt.

## Test plan
- Reset then all-zero state_in, default B=4:
  - out_valid rises exactly 4 cycles after the handshake.
  - state_out = 0x52 repeated 16 times.
- state_in = 0x000102030405060708090a0b0c0d0e0f -> state_out = 0x52096ad53036a538bf40a39e81f3d7fb.
- All bytes 0x63 -> all zero. All bytes 0xff -> all 0x7d.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_valid and state_out are stable throughout; in_ready = 0.
  - Raising out_ready together with in_valid captures the next word on the same edge.
  - The next result appears 4 cycles later.
- Reset mid-RUN: assert rst_n=0 after 2 processing cycles.
  - out_valid = 0 and state_out = 0 immediately; in_ready = 1.
  - A following word produces a correct result with no corruption.
- Elaborate with BYTES_PER_CYCLE=1 and with 16, using the 0x00..0x0f vector:
  - Latency is 16 cycles and 1 cycle respectively.
  - Output is identical to the expected value above.
